bp_fe_bht_updater: RTL
======================

# bp_fe_bht_updater

Tracks in-flight branch-direction predictions made by the front end and turns in-order branch resolutions into BHT update writes. It sits between the fetch/predict path, which produces `{bht index, predicted direction}` per predicted branch, and the BHT write port. It drives the BHT's write valid, write index and prediction-correct inputs. It is the writer side of the BHT read/predict and write/update protocol.

## Interface
Parameters:
- `bht_idx_width_p`, "inv", BHT index width; must match the BHT instance.
- `els_p`, 8, number of outstanding predictions tracked; power of two, ≥2.
- `cnt_width_lp` (local), `$clog2(els_p+1)`.

Ports:
- `clk_i`  in  1  single clock; all state is updated on its rising edge.
- `reset_i`  in  1  reset, asynchronous and active-high.
- `pred_v_i`  in  1  prediction issued this cycle.
- `pred_idx_i`  in  `bht_idx_width_p`  BHT index used for the prediction.
- `pred_taken_i`  in  1  predicted direction (1 = taken).
- `pred_ready_o`  out  1  queue not full; an entry is accepted only when `pred_v_i & pred_ready_o`.
- `res_v_i`  in  1  oldest outstanding branch resolved this cycle.
- `res_taken_i`  in  1  actual direction of that branch.
- `flush_i`  in  1  discard all outstanding predictions.
- `w_v_o`  out  1  BHT write valid.
- `idx_w_o`  out  `bht_idx_width_p`  BHT write index.
- `correct_o`  out  1  prediction matched the outcome.
- `count_o`  out  `cnt_width_lp`  current occupancy.
- `err_o`  out  1  sticky flag: a resolution arrived while the queue was empty.

## Operation
- Circular buffer of `els_p` entries `{idx, taken}` with read/write pointers and an occupancy counter.
- Full when `count == els_p`; empty when `count == 0`. Pointers wrap modulo `els_p`.
- **Enqueue:** on `pred_v_i & pred_ready_o`, write the entry at the write pointer, then advance it.
- `pred_ready_o = ~full`, computed from the registered count only. It does not depend on `res_v_i`, so a full queue refuses enqueue even when a dequeue happens in the same cycle.
- `pred_v_i` while not ready is ignored; no state changes.
- **Dequeue:** on `res_v_i & ~empty`, read the head entry, then advance the read pointer.
  - `correct = ~(head.taken ^ res_taken_i)`.
  - The update is registered to the outputs: `w_v_o=1`, `idx_w_o=head.idx`, `correct_o=correct`.
- When no update is issued, `w_v_o=0`. `idx_w_o` and `correct_o` hold their previous value.
- `res_v_i` while empty: no dequeue and no update; `err_o` sets and stays set until reset.
- Simultaneous enqueue and dequeue (not full, not empty): count is unchanged and both pointers advance.
- Enqueue into an empty queue cannot be resolved in the same cycle. The earliest resolution of that entry is the next cycle.
- **Flush** on `flush_i`:
  - A same-cycle `res_v_i` is processed first, and its update is still emitted.
  - A same-cycle `pred_v_i` is discarded.
  - Next cycle: count = 0, both pointers = 0, `pred_ready_o=1`.
- States (implicit in the counter): EMPTY, PARTIAL, FULL. Transitions are by ±1 per cycle, or to EMPTY on flush or reset.

## Timing
- Update latency: `res_v_i` in cycle N produces `w_v_o` high in cycle N+1 for exactly one cycle per resolution.
- Back-to-back resolutions give back-to-back `w_v_o` pulses.
- `pred_ready_o` and `count_o` reflect state after the previous edge.
- Reset values: `w_v_o=0`, `idx_w_o=0`, `correct_o=0`, `pred_ready_o=1`, `count_o=0`, `err_o=0`; pointers = 0.
- Reset asserted mid-operation clears all outstanding entries immediately (asynchronously).
- No update is emitted for entries lost to reset or flush.

## Structure
- `bp_fe_pkg` holds a `declare` macro for the pending-entry struct `bp_fe_bht_pending_entry_s {idx[bht_idx_width_p], taken}`, parameterised by `bht_idx_width_p`. The same macro is reused by the predictor front end.
- One sub-module: `bp_fe_bht_pending_queue`, a 1r1w circular buffer with pointers, count, full/empty and clear.
- The top level adds the correctness compare, the registered update outputs, the flush priority and the error flag.

## Test plan
- **Basic:** after reset, enqueue `(idx=3, taken=1)`, then resolve with `res_taken_i=1` → next cycle `w_v_o=1`, `idx_w_o=3`, `correct_o=1`, then `w_v_o=0` and `count_o=0`.
- **Ordering and mispredict:** enqueue `idx` 5/NT, 6/T, 7/T, then resolve T, T, NT on consecutive cycles → three consecutive pulses `(5,0)`, `(6,1)`, `(7,0)`.
- **Full with wrap-around:** `els_p=8`.
  - Enqueue 8 entries → `pred_ready_o=0`, `count_o=8`.
  - A 9th `pred_v_i` is ignored.
  - Resolve 1 and enqueue 1 repeatedly for 20 cycles → indices come out in order with no loss or duplication.
- **Flush collision:** 4 outstanding; in one cycle assert `flush_i`, `res_v_i` and `pred_v_i` → one update for the head entry, `count_o=0` next cycle, and the new prediction is dropped.
- **Empty resolution:** `res_v_i` with `count_o=0` → `w_v_o` stays 0, `err_o=1` and stays 1 until reset.
- **Async reset:** assert `reset_i` mid-cycle with 3 entries outstanding → all outputs reach their reset values immediately, and a subsequent resolution sets `err_o`.

Source files
------------

// File: rtl/bp_fe_pkg.sv
// Shared front-end types: pending BHT entry layout and the direction compare.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.

// Declares bp_fe_bht_pending_entry_s for a given BHT index width; the
// predictor front end expands the same macro so both sides agree on layout.
`define BP_FE_DECLARE_BHT_PENDING_ENTRY_S(idx_width_mp) \
  typedef struct packed { \
    logic [idx_width_mp-1:0] idx; \
    logic                    taken; \
  } bp_fe_bht_pending_entry_s

package bp_fe_pkg;

  // Occupancy view of the pending queue, derived from its counter.
  typedef enum logic [1:0] {
    e_occ_empty,
    e_occ_partial,
    e_occ_full
  } bp_fe_occ_e;

  // A prediction is correct when the predicted and actual directions agree.
  function automatic logic bp_fe_pred_correct(input logic pred_taken, input logic res_taken);
    return ~(pred_taken ^ res_taken);
  endfunction

endpackage

// File: rtl/bp_fe_bht_pending_queue.sv
// 1r1w circular buffer of in-flight predictions with count, full/empty and clear.
// Latency: enqueue visible at head one cycle after write; head read is combinational.
// Backpressure: caller must qualify enq_v_i with ~full_o and deq_v_i with ~empty_o.
module bp_fe_bht_pending_queue
  import bp_fe_pkg::*;
#(
  parameter  int idx_width_p  = 8,
  parameter  int els_p        = 8,
  localparam int ptr_width_lp = $clog2(els_p),
  localparam int cnt_width_lp = $clog2(els_p+1)
)
(
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    clr_i,
  input  logic                    enq_v_i,
  input  logic [idx_width_p-1:0]  enq_idx_i,
  input  logic                    enq_taken_i,
  input  logic                    deq_v_i,
  output logic [idx_width_p-1:0]  deq_idx_o,
  output logic                    deq_taken_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [cnt_width_lp-1:0] count_o
);

  `BP_FE_DECLARE_BHT_PENDING_ENTRY_S(idx_width_p);

  bp_fe_bht_pending_entry_s mem_r [els_p];
  logic [ptr_width_lp-1:0]  rptr_r, wptr_r;
  logic [cnt_width_lp-1:0]  count_r;
  bp_fe_occ_e               occ;

  // Classify occupancy from the registered count only.
  always_comb begin
    occ = e_occ_partial;
    if (count_r == '0)
      occ = e_occ_empty;
    else if (count_r == cnt_width_lp'(els_p))
      occ = e_occ_full;
  end

  assign full_o      = (occ == e_occ_full);
  assign empty_o     = (occ == e_occ_empty);
  assign count_o     = count_r;
  assign deq_idx_o   = mem_r[rptr_r].idx;
  assign deq_taken_o = mem_r[rptr_r].taken;

  // Pointer and count bookkeeping; pointers wrap naturally as els_p is a power of two.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rptr_r  <= '0;
      wptr_r  <= '0;
      count_r <= '0;
    end else if (clr_i) begin
      rptr_r  <= '0;
      wptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (enq_v_i) wptr_r <= wptr_r + ptr_width_lp'(1);
      if (deq_v_i) rptr_r <= rptr_r + ptr_width_lp'(1);
      unique case ({enq_v_i, deq_v_i})
        2'b10:   count_r <= count_r + cnt_width_lp'(1);
        2'b01:   count_r <= count_r - cnt_width_lp'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are meaningless once pointers are cleared, so no reset.
  always_ff @(posedge clk_i) begin
    if (enq_v_i & ~clr_i) begin
      mem_r[wptr_r].idx   <= enq_idx_i;
      mem_r[wptr_r].taken <= enq_taken_i;
    end
  end

endmodule

// File: rtl/bp_fe_bht_updater.sv
// Tracks in-flight BHT predictions and turns in-order resolutions into BHT writes.
// Latency: res_v_i in cycle N gives a one-cycle w_v_o pulse in cycle N+1.
// Backpressure: pred_ready_o low when full (registered count only); refused predictions are dropped.
module bp_fe_bht_updater
  import bp_fe_pkg::*;
#(
  parameter  int bht_idx_width_p = 8,
  parameter  int els_p           = 8,
  localparam int cnt_width_lp    = $clog2(els_p+1)
)
(
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       pred_v_i,
  input  logic [bht_idx_width_p-1:0] pred_idx_i,
  input  logic                       pred_taken_i,
  output logic                       pred_ready_o,
  input  logic                       res_v_i,
  input  logic                       res_taken_i,
  input  logic                       flush_i,
  output logic                       w_v_o,
  output logic [bht_idx_width_p-1:0] idx_w_o,
  output logic                       correct_o,
  output logic [cnt_width_lp-1:0]    count_o,
  output logic                       err_o
);

  logic                       full, empty;
  logic                       enq_v, deq_v;
  logic [bht_idx_width_p-1:0] head_idx;
  logic                       head_taken;

  // A flush drops the same-cycle prediction but still lets the head resolve.
  assign pred_ready_o = ~full;
  assign enq_v        = pred_v_i & ~full & ~flush_i;
  assign deq_v        = res_v_i & ~empty;

  bp_fe_bht_pending_queue #(
    .idx_width_p (bht_idx_width_p),
    .els_p       (els_p)
  ) queue (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .clr_i       (flush_i),
    .enq_v_i     (enq_v),
    .enq_idx_i   (pred_idx_i),
    .enq_taken_i (pred_taken_i),
    .deq_v_i     (deq_v),
    .deq_idx_o   (head_idx),
    .deq_taken_o (head_taken),
    .full_o      (full),
    .empty_o     (empty),
    .count_o     (count_o)
  );

  // Register the BHT update; index and correctness hold between updates.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      w_v_o     <= 1'b0;
      idx_w_o   <= '0;
      correct_o <= 1'b0;
    end else begin
      w_v_o <= deq_v;
      if (deq_v) begin
        idx_w_o   <= head_idx;
        correct_o <= bp_fe_pred_correct(head_taken, res_taken_i);
      end
    end
  end

  // Sticky error: a resolution with nothing outstanding means the streams diverged.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)
      err_o <= 1'b0;
    else if (res_v_i & empty)
      err_o <= 1'b1;
  end

endmodule
